// File: rtl/tone_pkg.sv
// tone_pkg: shared encodings for the tone sequencer and its tick generator.
package tone_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_UART_HOLD, ST_CHIME_ON, ST_CHIME_OFF} state_e;
   localparam int TONE_OFF = 0;
   localparam logic [1:0] SRC_NONE  = 2'd0;
   localparam logic [1:0] SRC_UART  = 2'd1;
   localparam logic [1:0] SRC_CHIME = 2'd2;
   localparam logic [4:0] CHIME_TONE_DEF = 5'h11;
endpackage

// File: rtl/tone_tick_gen.sv
// tone_tick_gen: one-cycle tick every TICK_CYC cycles, restartable by clr_i.
module tone_tick_gen #(
   parameter int CLK_FREQ = 12_000_000,
   parameter int TICK_MS  = 500
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);
   localparam int TICK_CYC = CLK_FREQ / 1000 * TICK_MS;
   localparam int CW = TICK_CYC > 1 ? $clog2(TICK_CYC) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   assign tick_o = cnt_q == CW'(TICK_CYC - 1);
   assign cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: arbitrates UART tone commands and the hourly chime onto one tone code.
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int                CLK_FREQ   = 12_000_000,
   parameter int                TICK_MS    = 500,
   parameter int                TONE_W     = 5,
   parameter logic [TONE_W-1:0] CHIME_TONE = TONE_W'(CHIME_TONE_DEF),
   parameter int                CHIME_MODE = 0,
   parameter int                BEEP_FIXED = 5,
   parameter int                HOLD_TICKS = 0
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              uart_done,
   input  logic [7:0]        uart_data,
   input  logic [3:0]        time_hour_high,
   input  logic [3:0]        time_hour_low,
   input  logic [3:0]        time_min_high,
   input  logic [3:0]        time_min_low,
   input  logic              chime_en,
   output logic [TONE_W-1:0] tone,
   output logic [1:0]        tone_src,
   output logic              chime_active
);
   localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
   state_e state_q, state_d;
   logic d0_q, d1_q, cmd_q, armed_q, armed_d;
   logic [TONE_W-1:0] code_q, code_d, code_in;
   logic [4:0] rem_q, rem_d;
   logic [HW-1:0] hold_q, hold_d;
   logic min_zero, trigger, tick, tick_clr, unused;
   function automatic logic [4:0] beep_count(input logic [3:0] hi, input logic [3:0] lo);
      logic [7:0] h;
      logic [7:0] m;
      h = 8'(hi) * 8'd10 + 8'(lo);
      m = h % 8'd12;
      if (CHIME_MODE == 0 || hi > 4'd9 || lo > 4'd9 || h > 8'd23) return 5'(BEEP_FIXED);
      return m == 8'd0 ? 5'd12 : 5'(m);
   endfunction
   assign unused   = ^(uart_data >> TONE_W);
   assign code_in  = uart_data[TONE_W-1:0];
   assign min_zero = time_min_high == 4'd0 && time_min_low == 4'd0;
   assign trigger  = armed_q && chime_en && min_zero;
   assign tick_clr = cmd_q || (state_q == ST_IDLE && trigger);
   tone_tick_gen #(.CLK_FREQ(CLK_FREQ), .TICK_MS(TICK_MS)) u_tick (
      .clk_i(sys_clk), .rst_i(sys_rst), .clr_i(tick_clr), .tick_o(tick)
   );
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      rem_d   = rem_q;
      hold_d  = hold_q;
      armed_d = !min_zero ? 1'b1 : trigger ? 1'b0 : armed_q;
      if (cmd_q) begin
         code_d  = code_in;
         hold_d  = '0;
         state_d = code_in != '0 ? ST_UART_HOLD : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (trigger) begin
               state_d = ST_CHIME_ON;
               rem_d   = beep_count(time_hour_high, time_hour_low);
            end
            ST_UART_HOLD: if (tick) begin
               hold_d = hold_q + 1'b1;
               if (HOLD_TICKS > 0 && hold_q == HW'(HOLD_TICKS - 1)) state_d = ST_IDLE;
            end
            ST_CHIME_ON: state_d = !chime_en ? ST_IDLE : tick ? ST_CHIME_OFF : ST_CHIME_ON;
            ST_CHIME_OFF:
               if (!chime_en) state_d = ST_IDLE;
               else if (tick) begin
                  state_d = rem_q <= 5'd1 ? ST_IDLE : ST_CHIME_ON;
                  rem_d   = rem_q - 5'd1;
               end
            default: state_d = ST_IDLE;
         endcase
      end
   end
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         state_q <= ST_IDLE;
         d0_q    <= 1'b0;
         d1_q    <= 1'b0;
         cmd_q   <= 1'b0;
         armed_q <= 1'b0;
         code_q  <= '0;
         rem_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         d0_q    <= uart_done;
         d1_q    <= d0_q;
         cmd_q   <= d0_q & ~d1_q;
         armed_q <= armed_d;
         code_q  <= code_d;
         rem_q   <= rem_d;
         hold_q  <= hold_d;
      end
   assign chime_active = state_q == ST_CHIME_ON || state_q == ST_CHIME_OFF;
   assign tone = state_q == ST_UART_HOLD ? code_q :
                 state_q == ST_CHIME_ON  ? CHIME_TONE : TONE_W'(TONE_OFF);
   assign tone_src = state_q == ST_UART_HOLD ? SRC_UART : chime_active ? SRC_CHIME : SRC_NONE;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed vector table plus hand sequences over three parameterisations.
module tb_tone_sequencer;
   logic clk = 1'b0, rst = 1'b0, done = 1'b0, en = 1'b1;
   logic [7:0] data = 8'h00;
   logic [3:0] hh = 4'd0, hl = 4'd0, mh = 4'd0, ml = 4'd0;
   logic [4:0] tone_w [3];
   logic [1:0] src_w [3];
   logic act_w [3];
   int checks = 0, errors = 0;
   typedef struct {
      logic       done;
      logic [7:0] data;
      logic [4:0] tone;
      logic [1:0] src;
   } vec_t;
   vec_t tbl [19];
   always #5 clk = ~clk;
   tone_sequencer #(.CLK_FREQ(10_000), .TICK_MS(1), .CHIME_MODE(0), .BEEP_FIXED(3), .HOLD_TICKS(0)) u0 (
      .sys_clk(clk), .sys_rst(rst), .uart_done(done), .uart_data(data),
      .time_hour_high(hh), .time_hour_low(hl), .time_min_high(mh), .time_min_low(ml),
      .chime_en(en), .tone(tone_w[0]), .tone_src(src_w[0]), .chime_active(act_w[0]));
   tone_sequencer #(.CLK_FREQ(10_000), .TICK_MS(1), .CHIME_MODE(1), .BEEP_FIXED(2), .HOLD_TICKS(0)) u1 (
      .sys_clk(clk), .sys_rst(rst), .uart_done(done), .uart_data(data),
      .time_hour_high(hh), .time_hour_low(hl), .time_min_high(mh), .time_min_low(ml),
      .chime_en(en), .tone(tone_w[1]), .tone_src(src_w[1]), .chime_active(act_w[1]));
   tone_sequencer #(.CLK_FREQ(10_000), .TICK_MS(1), .CHIME_MODE(0), .BEEP_FIXED(1), .HOLD_TICKS(2)) u2 (
      .sys_clk(clk), .sys_rst(rst), .uart_done(done), .uart_data(data),
      .time_hour_high(hh), .time_hour_low(hl), .time_min_high(mh), .time_min_low(ml),
      .chime_en(en), .tone(tone_w[2]), .tone_src(src_w[2]), .chime_active(act_w[2]));
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int k, input logic [4:0] et, input logic [1:0] es, input logic ea);
      checks++;
      if (tone_w[k] !== et || src_w[k] !== es || act_w[k] !== ea) begin
         errors++;
         $display("FAIL %s u%0d: tone=%h src=%0d act=%0b, expected tone=%h src=%0d act=%0b",
                  name, k, tone_w[k], src_w[k], act_w[k], et, es, ea);
      end
   endtask
   task automatic set_time(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      hh = a; hl = b; mh = c; ml = d;
   endtask
   task automatic uart_send(input logic [7:0] d);
      done = 1'b1; data = d;
      step();
      done = 1'b0;
      step();
   endtask
   task automatic chime_chk(input int k, input int n, input string name);
      for (int i = 0; i <= 2 * n * 10; i++) begin
         step();
         if (i == 2 * n * 10) chk(name, k, 5'h00, 2'd0, 1'b0);
         else if ((i / 10) % 2 == 0) chk(name, k, 5'h11, 2'd2, 1'b1);
         else chk(name, k, 5'h00, 2'd2, 1'b1);
      end
      repeat (20) begin
         step();
         chk({name, "_idle"}, k, 5'h00, 2'd0, 1'b0);
      end
   endtask
   initial begin
      tbl = '{
         '{1'b0, 8'h00, 5'h00, 2'd0}, '{1'b1, 8'h05, 5'h00, 2'd0}, '{1'b0, 8'h05, 5'h00, 2'd0},
         '{1'b0, 8'h05, 5'h05, 2'd1}, '{1'b0, 8'h00, 5'h05, 2'd1}, '{1'b1, 8'h09, 5'h05, 2'd1},
         '{1'b1, 8'h09, 5'h05, 2'd1}, '{1'b1, 8'h09, 5'h09, 2'd1}, '{1'b1, 8'h00, 5'h09, 2'd1},
         '{1'b0, 8'h00, 5'h09, 2'd1}, '{1'b1, 8'h00, 5'h09, 2'd1}, '{1'b0, 8'h00, 5'h09, 2'd1},
         '{1'b0, 8'h00, 5'h00, 2'd0}, '{1'b1, 8'hE6, 5'h00, 2'd0}, '{1'b0, 8'hE6, 5'h00, 2'd0},
         '{1'b0, 8'hE6, 5'h06, 2'd1}, '{1'b1, 8'h20, 5'h06, 2'd1}, '{1'b0, 8'h20, 5'h06, 2'd1},
         '{1'b0, 8'h20, 5'h00, 2'd0}};
      #1 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) chk("reset", k, 5'h00, 2'd0, 1'b0);
      set_time(4'd1, 4'd2, 4'd3, 4'd4);
      step();
      rst = 1'b0;
      foreach (tbl[i]) begin
         done = tbl[i].done; data = tbl[i].data;
         step();
         chk($sformatf("vec%0d", i), 0, tbl[i].tone, tbl[i].src, 1'b0);
      end
      set_time(4'd0, 4'd7, 4'd5, 4'd9); step(); set_time(4'd0, 4'd8, 4'd0, 4'd0);
      fork chime_chk(0, 3, "fixed3"); chime_chk(1, 8, "hour08"); join
      set_time(4'd1, 4'd5, 4'd5, 4'd9); step(); set_time(4'd1, 4'd6, 4'd0, 4'd0);
      fork chime_chk(1, 4, "hour16"); chime_chk(0, 3, "fixed3b"); join
      set_time(4'd2, 4'd3, 4'd5, 4'd9); step(); set_time(4'd0, 4'd0, 4'd0, 4'd0);
      chime_chk(1, 12, "hour00");
      set_time(4'd2, 4'hA, 4'd5, 4'd9); step(); set_time(4'd2, 4'hA, 4'd0, 4'd0);
      chime_chk(1, 2, "hour2A");
      set_time(4'd0, 4'd9, 4'd5, 4'd9); step(); set_time(4'd1, 4'd0, 4'd0, 4'd0);
      step();
      repeat (21) step();
      chk("beep2", 0, 5'h11, 2'd2, 1'b1);
      done = 1'b1; data = 8'h07; step(); done = 1'b0; step();
      chk("pre_abort", 0, 5'h11, 2'd2, 1'b1);
      step();
      chk("abort", 0, 5'h07, 2'd1, 1'b0);
      chk("abort", 1, 5'h07, 2'd1, 1'b0);
      repeat (60) begin step(); chk("abort_hold", 0, 5'h07, 2'd1, 1'b0); end
      uart_send(8'h00); step();
      chk("abort_off", 0, 5'h00, 2'd0, 1'b0);
      set_time(4'd1, 4'd0, 4'd5, 4'd9); step();
      done = 1'b1; data = 8'h04; step(); done = 1'b0; step();
      set_time(4'd1, 4'd1, 4'd0, 4'd0);
      step();
      chk("cmd_vs_trig", 0, 5'h04, 2'd1, 1'b0);
      uart_send(8'h00); step();
      repeat (30) begin step(); chk("no_chime", 0, 5'h00, 2'd0, 1'b0); end
      set_time(4'd1, 4'd1, 4'd3, 4'd0);
      uart_send(8'h03);
      for (int i = 0; i <= 20; i++) begin
         step();
         chk("hold2", 2, i < 20 ? 5'h03 : 5'h00, i < 20 ? 2'd1 : 2'd0, 1'b0);
      end
      uart_send(8'h05); step();
      chk("hold5", 2, 5'h05, 2'd1, 1'b0);
      step(); step();
      uart_send(8'h00);
      chk("hold5_pre", 2, 5'h05, 2'd1, 1'b0);
      step();
      chk("zero_cmd", 2, 5'h00, 2'd0, 1'b0);
      en = 1'b0;
      set_time(4'd1, 4'd1, 4'd5, 4'd9); step(); set_time(4'd1, 4'd2, 4'd0, 4'd0);
      repeat (15) begin step(); chk("en_off", 0, 5'h00, 2'd0, 1'b0); end
      set_time(4'd1, 4'd2, 4'd0, 4'd1); step();
      en = 1'b1; step();
      set_time(4'd1, 4'd2, 4'd5, 4'd9); step(); set_time(4'd1, 4'd3, 4'd0, 4'd0);
      step();
      chk("en_chime", 0, 5'h11, 2'd2, 1'b1);
      repeat (21) step();
      chk("en_beep2", 0, 5'h11, 2'd2, 1'b1);
      en = 1'b0; step();
      chk("en_drop", 0, 5'h00, 2'd0, 1'b0);
      en = 1'b1;
      repeat (15) begin step(); chk("en_noresume", 0, 5'h00, 2'd0, 1'b0); end
      set_time(4'd1, 4'd3, 4'd5, 4'd9); step(); set_time(4'd1, 4'd4, 4'd0, 4'd0);
      step();
      repeat (5) step();
      chk("rst_beep", 0, 5'h11, 2'd2, 1'b1);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) chk("async_rst", k, 5'h00, 2'd0, 1'b0);
      step();
      rst = 1'b0;
      repeat (20) begin step(); chk("post_rst", 0, 5'h00, 2'd0, 1'b0); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
